result_accum: RTL
=================

RESULT_ACCUM -- requirements
Module: result_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the x sample input.
REQ-002 SHALL have parameter ZWIDTH, default 8: width of the z sample input.
REQ-003 SHALL have parameter WINDOW, default 4: samples per result; legal range 1..255.
REQ-004 SHALL have parameter SUMWIDTH, default 20: accumulator width; legal only when SUMWIDTH >= WIDTH.
REQ-005 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: upstream datapath presents a sample.
REQ-008 SHALL have port in_ready, output, 1: block can accept a sample.
REQ-009 SHALL have port z, input, ZWIDTH: unsigned select-result sample from the datapath.
REQ-010 SHALL have port x, input, WIDTH: unsigned registered-difference sample from the datapath.
REQ-011 SHALL have port out_valid, output, 1: a window result is presented.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port sum, output, SUMWIDTH: sum of x over the window.
REQ-014 SHALL have port zmax, output, ZWIDTH: maximum z over the window.
REQ-015 SHALL have port ovf, output, 1: sticky flag; the accumulator exceeded SUMWIDTH during the window.

Function
REQ-016 SHALL accept a sample only in a cycle where in_valid and in_ready are both 1; samples in other cycles are ignored.
REQ-017 SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-019 SHALL, on an accept in IDLE, load sum=zero-extended x, zmax=z, ovf=0 and count=1, then go to ACCUM, or to HOLD if WINDOW=1.
REQ-020 SHALL, on an accept in ACCUM, update sum=sum+x, zmax=max(zmax,z) (unsigned) and count=count+1, and go to HOLD when the new count equals WINDOW.
REQ-021 SHALL assert out_valid exactly one cycle after the WINDOW-th accept, giving a latency of 1 cycle.
REQ-022 SHALL keep out_valid high in HOLD, with sum, zmax and ovf stable, until out_ready=1.
REQ-023 SHALL, on out_valid and out_ready both 1, go to IDLE next cycle with out_valid=0; no sample is accepted in that handshake cycle, which costs one bubble per window.
REQ-024 SHALL leave sum, zmax and ovf holding their last values outside HOLD; these values are meaningful only while out_valid=1.
REQ-025 SHALL hold all state when in_valid=0 in ACCUM; gaps of any length are allowed.
REQ-026 SHALL hold count in ceil(log2(WINDOW+1)) bits; count never exceeds WINDOW.

Reset
REQ-027 SHALL, while Rst=1 at a rising edge, set state=IDLE, count=0, sum=0, zmax=0, ovf=0 and out_valid=0; in_ready SHALL then be 1 in the following cycle.
REQ-028 SHALL discard any partial window or pending result on Rst mid-operation, with no output for it.
REQ-029 SHALL give Rst priority over any simultaneous accept or output handshake.

Configuration
REQ-030 SHALL, when macro RESULT_ACCUM_SAT_EN is defined, clamp sum at 2^SUMWIDTH-1 on overflow, set ovf=1, and hold sum there for the rest of the window.
REQ-031 SHALL, when RESULT_ACCUM_SAT_EN is undefined, let sum wrap modulo 2^SUMWIDTH on overflow and set ovf=1.
REQ-032 SHALL behave identically with and without RESULT_ACCUM_SAT_EN when no overflow occurs.

Verification
REQ-033 SHALL cover: WINDOW=4, x=1,2,3,4, z=5,9,2,7 on consecutive cycles -> out_valid one cycle after the 4th accept, sum=10, zmax=9, ovf=0.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> in_ready=0 and sum/zmax stable throughout; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-035 SHALL cover: SUMWIDTH=16, WINDOW=4, x=0xFFFF x4 -> with RESULT_ACCUM_SAT_EN sum=0xFFFF, ovf=1; without it sum=0xFFFC, ovf=1.
REQ-036 SHALL cover: Rst pulsed after 2 accepts, then x=10,20,30,40 -> sum=100 with no stale contribution; no output is produced for the aborted window.
REQ-037 SHALL cover: in_valid toggling 1,0,1,0,... for 8 cycles with x=3 -> exactly 4 accepts, sum=12.
REQ-038 SHALL cover: WINDOW=1, x=0x1234, z=0x80 -> out_valid the next cycle with sum=0x01234 and zmax=0x80.

Source files
------------

// File: rtl/result_accum.sv
// result_accum: collects WINDOW accepted samples and reports the sum of x,
// the unsigned maximum of z and a sticky overflow flag for the window.
// The result is held until downstream takes it.
// Optional feature macro: RESULT_ACCUM_SAT_EN. When it is defined, sum
// saturates at all-ones on overflow. Otherwise sum wraps.
module result_accum #(
  parameter int WIDTH    = 16,
  parameter int ZWIDTH   = 8,
  parameter int WINDOW   = 4,
  parameter int SUMWIDTH = 20
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ZWIDTH-1:0]   z,
  input  logic [WIDTH-1:0]    x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUMWIDTH-1:0] sum,
  output logic [ZWIDTH-1:0]   zmax,
  output logic                ovf
);

  localparam int CW = $clog2(WINDOW + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]          state;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_inc;
  logic                accept;
  logic                first;
  logic [SUMWIDTH:0]   sum_wide;
  logic                carry;
  logic [SUMWIDTH-1:0] sum_next;
  logic [ZWIDTH-1:0]   zmax_next;
  logic                ovf_next;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign first     = (state == IDLE);

  // Next-window values: the first sample of a window starts from zero,
  // later samples build on the registered totals.
  always_comb begin
    count_inc = first ? CW'(1) : count + CW'(1);
    sum_wide  = (first ? {(SUMWIDTH+1){1'b0}} : {1'b0, sum})
              + {{(SUMWIDTH+1-WIDTH){1'b0}}, x};
    carry     = sum_wide[SUMWIDTH];
    ovf_next  = (first ? 1'b0 : ovf) | carry;
`ifdef RESULT_ACCUM_SAT_EN
    sum_next  = carry ? {SUMWIDTH{1'b1}} : sum_wide[SUMWIDTH-1:0];
`else
    sum_next  = sum_wide[SUMWIDTH-1:0];
`endif
    zmax_next = (first || (z > zmax)) ? z : zmax;
  end

  // Window state machine and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      count <= '0;
      sum   <= '0;
      zmax  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            sum   <= sum_next;
            zmax  <= zmax_next;
            ovf   <= ovf_next;
            count <= count_inc;
            state <= (count_inc == CW'(WINDOW)) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
